// File: rtl/uart_pkg.sv
// Shared constants and launch-FSM encoding for the UART transmit FIFO.
// Imported by uart_fifo_ram and uart_tx_fifo.
package uart_pkg;

  localparam int D_BITS_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; the pointers in the parent decide validity.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int D_BITS = D_BITS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [D_BITS-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [D_BITS-1:0] rdata
);

  logic [D_BITS-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO that launches one word per frame into a UART transmitter.
// Define UART_TX_FIFO_LEVEL_EN to expose the registered occupancy port level.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int D_BITS = D_BITS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [D_BITS-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              tx_start,
  output logic [D_BITS-1:0] tx_din,
  input  logic              tx_done_tick
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [ADDR_W:0]   level
`endif
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_acc, pop;
  logic [D_BITS-1:0] head;

  // full is registered, so a write racing a pop while full is dropped
  assign wr_acc = wr_en & ~full;

  uart_fifo_ram #(
    .D_BITS (D_BITS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (tx_done_tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({wr_acc, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_q    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      tx_start <= 1'b0;
      tx_din   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      full     <= (cnt_d == DEPTH);
      empty    <= (cnt_d == '0);
      tx_start <= pop;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      if (pop) begin
        tx_din <= head;
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

`ifdef UART_TX_FIFO_LEVEL_EN
  assign level = cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue-based reference model.
// Set UART_TX_FIFO_LEVEL_EN to also check the level port.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, overflow, tx_start;
  logic [7:0] tx_din;
  logic       tx_done_tick;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [4:0] level;
`endif

  uart_tx_fifo #(.D_BITS(8), .ADDR_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick)
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    .level        (level)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: words waiting, transmitter busy, last launched word
  logic [7:0] q[$];
  bit         busy;
  bit         ovf;
  logic [7:0] exp_din;
  int         n_launch;
  int         n_wr;

  // transmitter emulation
  bit done_en;
  int pend;
  int dly_lo, dly_hi;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp,
               $time);
    end
  endtask

  task automatic chk_outputs(input bit launch);
    chk("tx_start", 32'(tx_start), 32'(launch));
    chk("tx_din", 32'(tx_din), 32'(exp_din));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == 16));
    chk("overflow", 32'(overflow), 32'(ovf));
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("level", 32'(level), 32'(q.size()));
`endif
  endtask

  // one clock: drive at negedge, advance model at posedge, check at negedge
  task automatic cyc(input bit wr, input logic [7:0] d, input bit xdone);
    bit done, launch, acc;
    done = xdone || (done_en && pend == 0);
    wr_en = wr;
    wr_data = d;
    tx_done_tick = done;
    @(posedge clk);
    launch = !busy && q.size() != 0;
    acc = wr && q.size() != 16;
    if (wr && !acc) ovf = 1'b1;
    if (launch) begin
      exp_din = q.pop_front();
      busy = 1'b1;
      pend = $urandom_range(dly_hi, dly_lo);
      n_launch++;
    end else if (busy && done) begin
      busy = 1'b0;
      pend = -1;
    end else if (pend > 0) begin
      pend--;
    end
    if (acc) begin
      q.push_back(d);
      n_wr++;
    end
    @(negedge clk);
    chk_outputs(launch);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wr_en = 1'b0;
    tx_done_tick = 1'b0;
    #1;
    q.delete();
    busy = 1'b0;
    ovf = 1'b0;
    exp_din = '0;
    pend = -1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_din", 32'(tx_din), 32'd0);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("rst_level", 32'(level), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int i;
    for (i = 0; i < budget && (q.size() != 0 || busy); i++) cyc(0, 8'h00, 0);
    if (q.size() != 0 || busy) chk("drain_timeout", 32'(i), 32'(budget + 1));
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    tx_done_tick = 1'b0;
    done_en = 1'b0;
    dly_lo = 0;
    dly_hi = 0;
    n_launch = 0;
    n_wr = 0;
    @(negedge clk);
    do_reset();

    // single word, transmitter silent: exactly one launch
    cyc(1, 8'hA5, 0);
    repeat (6) cyc(0, 8'h00, 0);
    chk("a5_launches", 32'(n_launch), 32'd1);
    cyc(0, 8'h00, 1);
    repeat (3) cyc(0, 8'h00, 0);

    // done ticks while idle and empty are ignored
    repeat (3) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    chk("idle_done_launches", 32'(n_launch), 32'd1);

    // three words, fixed 20-cycle frames
    done_en = 1'b1;
    dly_lo = 19;
    dly_hi = 19;
    cyc(1, 8'h01, 0);
    cyc(1, 8'h02, 0);
    cyc(1, 8'h03, 0);
    drain(200);
    chk("three_launches", 32'(n_launch), 32'd4);
    repeat (3) cyc(0, 8'h00, 0);

    // fill past capacity with the transmitter stalled
    done_en = 1'b0;
    for (int i = 0; i < 17; i++) cyc(1, 8'($urandom), 0);
    chk("full_after_17", 32'(full), 32'd1);
    cyc(1, 8'hEE, 0);
    chk("ovf_after_18", 32'(overflow), 32'd1);
    cyc(0, 8'h00, 1);
    done_en = 1'b1;
    dly_lo = 0;
    dly_hi = 3;
    drain(300);

    // reset during a frame drops everything
    done_en = 1'b0;
    cyc(1, 8'h11, 0);
    cyc(1, 8'h22, 0);
    cyc(1, 8'h33, 0);
    cyc(0, 8'h00, 0);
    @(negedge clk);
    do_reset();
    repeat (5) cyc(0, 8'h00, 1);
    cyc(1, 8'h5A, 0);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 1);

    // random stream of 40 words with random frame lengths
    done_en = 1'b1;
    dly_lo = 0;
    dly_hi = 6;
    n_wr = 0;
    n_launch = 0;
    for (int i = 0; n_wr < 40 && i < 2000; i++) begin
      if (q.size() < 16 && $urandom_range(99, 0) < 70)
        cyc(1, 8'($urandom), 0);
      else
        cyc(0, 8'h00, 0);
    end
    chk("stream_writes", 32'(n_wr), 32'd40);
    drain(600);
    chk("stream_launches", 32'(n_launch), 32'd40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter D_BITS, default 8, data word width; SHALL match the downstream transmitter's data width.
REQ-002 Parameter ADDR_W, default 4, FIFO address width; depth SHALL be 2**ADDR_W words.
REQ-003 clk  input  1  system clock; all state SHALL update on posedge clk.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  write request from the producer.
REQ-006 wr_data  input  D_BITS  word to enqueue.
REQ-007 full  output  1  FIFO holds 2**ADDR_W words.
REQ-008 empty  output  1  FIFO holds 0 words.
REQ-009 overflow  output  1  sticky flag: a write was attempted while full.
REQ-010 tx_start  output  1  one-cycle launch pulse to the transmitter.
REQ-011 tx_din  output  D_BITS  word presented to the transmitter; valid while tx_start=1.
REQ-012 tx_done_tick  input  1  one-cycle pulse from the transmitter: frame (stop bit) complete.
REQ-013 level  output  ADDR_W+1  current occupancy, 0..2**ADDR_W; present only under REQ-029.

Function
REQ-014 The write is accepted iff wr_en=1 and full=0; the word is stored at the write pointer and the write pointer increments modulo 2**ADDR_W.
REQ-015 If wr_en=1 while full=1, the write SHALL be discarded, storage and pointers unchanged, and overflow set to 1 on the next edge; overflow clears only on reset.
REQ-016 Occupancy is an ADDR_W+1-bit counter: +1 on accepted write only, -1 on pop only, unchanged on simultaneous accepted write and pop.
REQ-017 full and empty SHALL be registered and derived from occupancy, so both are valid the cycle after the causing edge.
REQ-018 The launch FSM SHALL have exactly two states: IDLE and BUSY.
REQ-019 IDLE with empty=0: on the next edge tx_start=1, tx_din=head word, read pointer increments (pop), and the state becomes BUSY.
REQ-020 IDLE with empty=1: tx_start stays 0 and the state stays IDLE; a write in the same cycle SHALL NOT launch until empty is observed 0.
REQ-021 tx_start SHALL be high for exactly one cycle per popped word; tx_din SHALL hold that word until the next launch.
REQ-022 BUSY: wait for tx_done_tick=1, then return to IDLE; a back-to-back launch is possible on the cycle after the return (one idle cycle between frames, minimum).
REQ-023 A tx_done_tick received in IDLE SHALL be ignored.
REQ-024 Words SHALL be launched in strict write order; pointers wrap from 2**ADDR_W-1 to 0 without gap or duplication.
REQ-025 When full=1, a launch pop and a write on the same edge: the write SHALL be rejected (full is registered), and the pop proceeds.

Reset
REQ-026 On reset_n=0, immediately: state=IDLE, pointers=0, occupancy=0, empty=1, full=0, overflow=0, tx_start=0, tx_din=0, level=0.
REQ-027 Reset mid-frame SHALL discard all stored words; RAM contents need not be cleared.
REQ-028 After release, the first launch SHALL occur no earlier than the second edge following the first accepted write.

Configuration
REQ-029 Macro UART_TX_FIFO_LEVEL_EN: when defined, port level exists and reflects occupancy (registered); when undefined, port level is absent and all other behaviour is identical.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state encoding (IDLE=0, BUSY=1) and the default D_BITS/ADDR_W constants.
REQ-031 Storage SHALL be a sub-module uart_fifo_ram (2**ADDR_W x D_BITS, one synchronous write port, one asynchronous read port); pointer, flag and FSM logic stay in uart_tx_fifo.

Verification
REQ-032 Reset, then write 0xA5 -> tx_start pulses once 2 cycles later with tx_din=0xA5; empty=1 afterwards; no second pulse until tx_done_tick.
REQ-033 Write 0x01,0x02,0x03 back-to-back; return tx_done_tick 20 cycles after each launch -> three tx_start pulses carrying 0x01,0x02,0x03 in order, each 1 cycle after the previous done.
REQ-034 With tx_done_tick held 0, write 17 words (ADDR_W=4) -> first popped, 16 stored, full=1 after the 17th accepted write; an 18th write -> overflow=1, data unchanged.
REQ-035 Pulse tx_done_tick in IDLE with empty FIFO -> no tx_start, state remains IDLE.
REQ-036 Fill 3 words, assert reset_n=0 during BUSY -> empty=1, tx_start=0, overflow=0 immediately; after release, no launch until a new write.
REQ-037 Stream 40 words through with random done delays (ADDR_W=4, pointer wrap twice) -> output sequence equals input sequence, level (with UART_TX_FIFO_LEVEL_EN) never exceeds 16.
